// File: rtl/seg_scan_sched.sv
// Scan scheduler for a 7-digit active-low seven-segment display.
// Time-multiplexes two page sources with frame-aligned arbitration, edit-digit blink and inter-digit blanking.
module seg_scan_sched #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK        = 64,
  parameter int BLINK_FRAMES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  page_req,
  input  logic [48:0] dig_a,
  input  logic [48:0] dig_b,
  input  logic        edit_en,
  input  logic [2:0]  edit_pos,
  output logic [7:0]  led,
  output logic [6:0]  content,
  output logic [1:0]  grant,
  output logic        page_ack,
  output logic        frame_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK);
  localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] p_r;
  logic [2:0]    d_r;
  logic          phase_r;
  logic [FW-1:0] fcnt_r;
  logic [6:0]    word_r;

  logic          tick_s;
  logic          frame_end_s;
  logic [2:0]    next_d_s;
  logic [1:0]    next_grant_s;
  logic [1:0]    latch_grant_s;
  logic [6:0]    next_word_s;
  logic          blink_s;
  logic [7:0]    led_s;
  logic [6:0]    content_s;

  function automatic logic [6:0] digit_word(input logic [48:0] w, input logic [2:0] k);
    case (k)
      3'd0:    return w[6:0];
      3'd1:    return w[13:7];
      3'd2:    return w[20:14];
      3'd3:    return w[27:21];
      3'd4:    return w[34:28];
      3'd5:    return w[41:35];
      3'd6:    return w[48:42];
      default: return 7'h7F;
    endcase
  endfunction

  // Slot timing, frame-boundary arbitration and the word to latch for the next digit
  always_comb begin
    tick_s      = (p_r == P_LAST);
    frame_end_s = tick_s && (d_r == 3'd6);
    if (d_r == 3'd6) begin
      next_d_s = 3'd0;
    end else begin
      next_d_s = d_r + 3'd1;
    end
    if (page_req[1]) begin
      next_grant_s = 2'b10;
    end else if (page_req[0]) begin
      next_grant_s = 2'b01;
    end else begin
      next_grant_s = grant;
    end
    // A new owner must already supply digit 0 of the frame it wins
    if (frame_end_s) begin
      latch_grant_s = next_grant_s;
    end else begin
      latch_grant_s = grant;
    end
    if (latch_grant_s[1]) begin
      next_word_s = digit_word(dig_b, next_d_s);
    end else begin
      next_word_s = digit_word(dig_a, next_d_s);
    end
  end

  // Display drive for the current slot position, before the output register
  always_comb begin
    blink_s = (grant == 2'b10) && edit_en && (edit_pos == d_r) && phase_r;
    if (p_r < P_BLANK) begin
      led_s     = 8'hFF;
      content_s = 7'h7F;
    end else begin
      led_s = {1'b1, ~(7'h01 << d_r)};
      if (blink_s) begin
        content_s = 7'h7F;
      end else begin
        content_s = word_r;
      end
    end
  end

  // Scan counters, grant, blink phase, slot latch and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r        <= '0;
      d_r        <= 3'd0;
      phase_r    <= 1'b0;
      fcnt_r     <= '0;
      word_r     <= digit_word(dig_a, 3'd0);
      grant      <= 2'b01;
      led        <= 8'hFF;
      content    <= 7'h7F;
      page_ack   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      led        <= led_s;
      content    <= content_s;
      page_ack   <= 1'b0;
      frame_done <= 1'b0;
      if (tick_s) begin
        p_r    <= '0;
        d_r    <= next_d_s;
        word_r <= next_word_s;
        if (frame_end_s) begin
          frame_done <= 1'b1;
          grant      <= next_grant_s;
          page_ack   <= (next_grant_s != grant);
          if (fcnt_r == F_LAST) begin
            fcnt_r  <= '0;
            phase_r <= ~phase_r;
          end else begin
            fcnt_r <= fcnt_r + FW'(1);
          end
        end else begin
          fcnt_r <= fcnt_r;
        end
      end else begin
        p_r <= p_r + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_sched.sv
// Self-checking bench for seg_scan_sched against a frame/slot arithmetic reference model.
module tb_seg_scan_sched;

  localparam int CD = 8;
  localparam int BL = 2;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  page_req = 2'b00;
  logic [48:0] dig_a = '0;
  logic [48:0] dig_b = '0;
  logic        edit_en = 1'b0;
  logic [2:0]  edit_pos = 3'd0;
  logic [7:0]  led;
  logic [6:0]  content;
  logic [1:0]  grant;
  logic        page_ack;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_sched #(.CLK_DIV(CD), .BLANK(BL), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .page_req(page_req), .dig_a(dig_a), .dig_b(dig_b),
    .edit_en(edit_en), .edit_pos(edit_pos), .led(led), .content(content),
    .grant(grant), .page_ack(page_ack), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: position in the scan is derived from the cycle count since reset
  int         n;
  logic [1:0] m_grant;
  logic [6:0] m_snap;
  logic [7:0] e_led;
  logic [6:0] e_con;
  logic [1:0] e_grant;
  logic       e_ack, e_fd;

  always @(posedge clk) begin
    int off, slot, frame, nxt;
    logic [1:0] ng;
    if (rst) begin
      n = 0; m_grant = 2'b01; m_snap = dig_a[6:0];
      e_led = 8'hFF; e_con = 7'h7F; e_grant = 2'b01; e_ack = 1'b0; e_fd = 1'b0;
    end else begin
      off = n % CD; slot = (n / CD) % 7; frame = n / (7 * CD);
      if (off < BL) begin
        e_led = 8'hFF; e_con = 7'h7F;
      end else begin
        e_led = 8'hFF; e_led[slot] = 1'b0;
        if (m_grant == 2'b10 && edit_en && int'(edit_pos) == slot && ((frame / BF) % 2) == 1)
          e_con = 7'h7F;
        else
          e_con = m_snap;
      end
      e_ack = 1'b0; e_fd = 1'b0;
      if (off == CD - 1) begin
        if (slot == 6) begin
          e_fd = 1'b1;
          ng = page_req[1] ? 2'b10 : (page_req[0] ? 2'b01 : m_grant);
          e_ack = (ng != m_grant);
          m_grant = ng;
        end
        nxt = (slot + 1) % 7;
        m_snap = m_grant[1] ? dig_b[7*nxt +: 7] : dig_a[7*nxt +: 7];
      end
      e_grant = m_grant;
      n++;
    end
  end

  logic [19:0] obs, expv;
  assign obs  = {led, content, grant, page_ack, frame_done};
  assign expv = {e_led, e_con, e_grant, e_ack, e_fd};

  task automatic test_reset();
    rst = 1'b1;
    dig_a = 49'({$urandom(), $urandom()});
    dig_b = 49'({$urandom(), $urandom()});
    repeat (3) @(negedge clk);
    checks++;
    if (obs !== {8'hFF, 7'h7F, 2'b01, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state: got %h exp %h", obs, {8'hFF, 7'h7F, 2'b01, 1'b0, 1'b0});
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL scan cycle %0d: got %h exp %h", c, obs, expv); end
      checks++;
      if (led[7] !== 1'b1) begin errors++; $display("FAIL scan_led7 cycle %0d: got %b exp 1", c, led[7]); end
      if (c == 3 || c == 8) begin
        checks++;
        if ({led, content} !== {8'hFE, dig_a[6:0]}) begin
          errors++; $display("FAIL scan_digit0 cycle %0d: got %h exp %h", c, {led, content}, {8'hFE, dig_a[6:0]});
        end
      end
      if (c == 9 || c == 51 || c == 57) begin
        checks++;
        if (led !== ((c == 51) ? 8'hBF : 8'hFF)) begin
          errors++; $display("FAIL scan_led cycle %0d: got %h", c, led);
        end
      end
      if (c == 56 || c == 112) begin
        checks++;
        if (frame_done !== 1'b1) begin errors++; $display("FAIL frame_done cycle %0d: got %b exp 1", c, frame_done); end
      end
    end
  endtask

  task automatic test_arbitration();
    rst = 1'b1; page_req = 2'b00;
    dig_a = 49'({$urandom(), $urandom()});
    dig_b = 49'({$urandom(), $urandom()});
    @(negedge clk); rst = 1'b0;
    for (int c = 1; c <= 180; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL arbitration cycle %0d: got %h exp %h", c, obs, expv); end
      if (c == 55) begin
        checks++;
        if ({grant, page_ack} !== {2'b01, 1'b0}) begin errors++; $display("FAIL arb_hold cycle 55: got %b exp 010", {grant, page_ack}); end
      end
      if (c == 56) begin
        checks++;
        if ({grant, page_ack} !== {2'b10, 1'b1}) begin errors++; $display("FAIL arb_switch cycle 56: got %b exp 101", {grant, page_ack}); end
      end
      if (c == 60) begin
        checks++;
        if (content !== dig_b[6:0]) begin errors++; $display("FAIL arb_new_source: got %h exp %h", content, dig_b[6:0]); end
      end
      if (c == 20) page_req = 2'b10;
      if (c == 70) page_req = 2'b11;
      if (c == 130) page_req = 2'b00;
    end
  endtask

  task automatic test_blink();
    rst = 1'b1; page_req = 2'b10; edit_en = 1'b1; edit_pos = 3'd3;
    dig_a = 49'({$urandom(), $urandom()});
    dig_b = 49'({$urandom(), $urandom()});
    @(negedge clk); rst = 1'b0;
    for (int c = 1; c <= 680; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL blink cycle %0d: got %h exp %h", c, obs, expv); end
      if (c == 141) begin
        checks++;
        if ({led, content} !== {8'hF7, 7'h7F}) begin errors++; $display("FAIL blink_on: got %h exp %h", {led, content}, {8'hF7, 7'h7F}); end
      end
      if (c == 253 || c == 365 || c == 589) begin
        checks++;
        if ({led, content} !== {8'hF7, dig_b[27:21]}) begin
          errors++; $display("FAIL blink_off cycle %0d: got %h exp %h", c, {led, content}, {8'hF7, dig_b[27:21]});
        end
      end
      if (c == 336) edit_pos = 3'd7;
      if (c == 448) begin edit_pos = 3'd3; edit_en = 1'b0; end
    end
  endtask

  task automatic test_mid_slot();
    rst = 1'b1; page_req = 2'b00; edit_en = 1'b0;
    dig_a = 49'({$urandom(), $urandom()});
    dig_a[6:0] = 7'h40;
    @(negedge clk); rst = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL mid_slot cycle %0d: got %h exp %h", c, obs, expv); end
      if (c == 6 || c == 8 || c == 60) begin
        checks++;
        if (content !== ((c == 60) ? 7'h79 : 7'h40)) begin errors++; $display("FAIL mid_slot_word cycle %0d: got %h", c, content); end
      end
      if (c == 4) dig_a[6:0] = 7'h79;
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; page_req = 2'b10;
    dig_a = 49'({$urandom(), $urandom()});
    dig_b = 49'({$urandom(), $urandom()});
    @(negedge clk); rst = 1'b0;
    for (int c = 1; c <= 93; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL pre_reset cycle %0d: got %h exp %h", c, obs, expv); end
    end
    checks++;
    if (grant !== 2'b10) begin errors++; $display("FAIL pre_reset_grant: got %b exp 10", grant); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== {8'hFF, 7'h7F, 2'b01, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_mid: got %h exp %h", obs, {8'hFF, 7'h7F, 2'b01, 1'b0, 1'b0});
    end
    rst = 1'b0; page_req = 2'b00;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL post_reset cycle %0d: got %h exp %h", c, obs, expv); end
      if (c == 3) begin
        checks++;
        if ({led, content} !== {8'hFE, dig_a[6:0]}) begin
          errors++; $display("FAIL post_reset_digit0: got %h exp %h", {led, content}, {8'hFE, dig_a[6:0]});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_arbitration();
    test_blink();
    test_mid_slot();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
